// File: rtl/alu_pkg.sv
// Shared opcode map, flag bit positions and datapath width for the ALU dispatch slice.
package alu_pkg;

    localparam int DATA_W = 16;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_ADD  = 8'h01;
    localparam logic [7:0] OP_SUB  = 8'h02;
    localparam logic [7:0] OP_AND  = 8'h03;
    localparam logic [7:0] OP_OR   = 8'h04;
    localparam logic [7:0] OP_XOR  = 8'h05;
    localparam logic [7:0] OP_NOT  = 8'h06;
    localparam logic [7:0] OP_SHL  = 8'h07;
    localparam logic [7:0] OP_SHR  = 8'h08;
    localparam logic [7:0] OP_SRA  = 8'h09;
    localparam logic [7:0] OP_ROL  = 8'h0A;
    localparam logic [7:0] OP_ROR  = 8'h0B;
    localparam logic [7:0] OP_MUL  = 8'h0C;
    localparam logic [7:0] OP_MIN  = 8'h0D;
    localparam logic [7:0] OP_MAX  = 8'h0E;
    localparam logic [7:0] OP_INC  = 8'h0F;
    localparam logic [7:0] OP_DEC  = 8'h10;
    localparam logic [7:0] OP_NEG1 = 8'h11;
    localparam logic [7:0] OP_HALT = 8'hFF;

    localparam int FLAG_C = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 3;

    function automatic logic is_alu_op(input logic [7:0] op);
        return (op >= OP_ADD) && (op <= OP_NEG1);
    endfunction

    function automatic logic is_illegal_op(input logic [7:0] op);
        return (op > OP_NEG1) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/alu_dispatch_regfile.sv
// General-purpose register file: two combinational read ports, one synchronous write port, R0 reads zero.
module regfile #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 8,
    parameter int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] regs [NREGS];

    // Writes to R0 are dropped so the zero register never holds data.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/alu_dispatch.sv
// Two-stage instruction dispatch to an external ALU: operand fetch with forwarding into EX, then commit
// to the register file and architectural flags. A RUN/HALT state gates instruction acceptance.
module alu_dispatch #(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int NREGS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [7:0]               instr_op,
    input  logic [2:0]               instr_rd,
    input  logic [2:0]               instr_rs1,
    input  logic [2:0]               instr_rs2,
    input  logic                     instr_imm_en,
    input  logic [DATA_W-1:0]        instr_imm,
    input  logic                     resume,
    output logic [7:0]               alu_opcode,
    output logic signed [DATA_W-1:0] alu_a,
    output logic signed [DATA_W-1:0] alu_b,
    input  logic signed [DATA_W-1:0] alu_result,
    input  logic [15:0]              alu_flags,
    output logic                     wb_valid,
    output logic [2:0]               wb_rd,
    output logic [DATA_W-1:0]        wb_data,
    output logic [3:0]               flags_q,
    output logic                     err
);

    import alu_pkg::*;

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_HALT = 1'b1;

    // Handshake: an instruction transfers on a rising edge where instr_valid and instr_ready are both high;
    // instr_ready depends only on the RUN/HALT state and rst, never on instr_valid.
    logic              state;
    logic              accept;
    logic              is_halt;
    logic [2:0]        ex_rd;
    logic              ex_writes;
    logic              ex_illegal;
    logic              fwd_a;
    logic              fwd_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              flags_hi_unused;

    assign instr_ready = (state == ST_RUN) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign is_halt     = (instr_op == OP_HALT);

    // HALT never enters EX, so alu_opcode alone tells what EX holds.
    assign ex_writes  = is_alu_op(alu_opcode);
    assign ex_illegal = is_illegal_op(alu_opcode);

    assign fwd_a = ex_writes && (ex_rd == instr_rs1) && (instr_rs1 != 3'd0);
    assign fwd_b = ex_writes && (ex_rd == instr_rs2) && (instr_rs2 != 3'd0);
    assign op_a  = fwd_a ? alu_result : rdata_a;
    assign op_b  = instr_imm_en ? instr_imm : (fwd_b ? alu_result : rdata_b);

    assign flags_hi_unused = ^alu_flags[15:4];

    regfile #(
        .DATA_W(DATA_W),
        .NREGS (NREGS),
        .IDX_W (3)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (ex_writes && !rst),
        .waddr  (ex_rd),
        .wdata  (alu_result),
        .raddr_a(instr_rs1),
        .rdata_a(rdata_a),
        .raddr_b(instr_rs2),
        .rdata_b(rdata_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_RUN;
            alu_opcode <= OP_NOP;
            alu_a      <= '0;
            alu_b      <= '0;
            ex_rd      <= 3'd0;
            wb_valid   <= 1'b0;
            wb_rd      <= 3'd0;
            wb_data    <= '0;
            flags_q    <= 4'd0;
            err        <= 1'b0;
        end else begin
            if ((state == ST_RUN) && accept && is_halt) begin
                state <= ST_HALT;
            end else if ((state == ST_HALT) && resume) begin
                state <= ST_RUN;
            end

            // Operands hold their last values when EX empties.
            if (accept && !is_halt) begin
                alu_opcode <= instr_op;
                ex_rd      <= instr_rd;
                alu_a      <= op_a;
                alu_b      <= op_b;
            end else begin
                alu_opcode <= OP_NOP;
            end

            wb_valid <= ex_writes;
            if (ex_writes) begin
                wb_rd           <= ex_rd;
                wb_data         <= alu_result;
                flags_q[FLAG_Z] <= alu_flags[FLAG_Z];
                flags_q[FLAG_V] <= alu_flags[FLAG_V];
                if ((alu_opcode == OP_ADD) || (alu_opcode == OP_SUB)) begin
                    flags_q[FLAG_C] <= alu_flags[FLAG_C];
                    flags_q[FLAG_N] <= alu_flags[FLAG_N];
                end
            end

            if (ex_illegal) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a small behavioural ALU (ADD/SUB/AND) closing the EX loop.
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_op;
    logic [2:0]  instr_rd, instr_rs1, instr_rs2;
    logic        instr_imm_en;
    logic [15:0] instr_imm;
    logic        resume;
    logic [7:0]  alu_opcode;
    logic [15:0] alu_a, alu_b;
    logic [15:0] alu_result;
    logic [15:0] alu_flags;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [3:0]  flags_q;
    logic        err;

    int checks = 0;
    int errors = 0;

    alu_dispatch dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs1   (instr_rs1),
        .instr_rs2   (instr_rs2),
        .instr_imm_en(instr_imm_en),
        .instr_imm   (instr_imm),
        .resume      (resume),
        .alu_opcode  (alu_opcode),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flags_q     (flags_q),
        .err         (err)
    );

    always #5 clk = ~clk;

    // External ALU model; carry on SUB means borrow.
    logic [16:0] wide;
    logic        c_f, v_f;
    always_comb begin
        wide       = 17'd0;
        c_f        = 1'b0;
        v_f        = 1'b0;
        alu_result = 16'd0;
        case (alu_opcode)
            8'h01: begin
                wide       = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = wide[15:0];
                c_f        = wide[16];
                v_f        = (alu_a[15] == alu_b[15]) && (alu_result[15] != alu_a[15]);
            end
            8'h02: begin
                wide       = {1'b0, alu_a} - {1'b0, alu_b};
                alu_result = wide[15:0];
                c_f        = wide[16];
                v_f        = (alu_a[15] != alu_b[15]) && (alu_result[15] != alu_a[15]);
            end
            8'h03: alu_result = alu_a & alu_b;
            default: alu_result = 16'd0;
        endcase
        alu_flags = {12'd0, v_f, (alu_result == 16'd0), alu_result[15], c_f};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [7:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic ie, input logic [15:0] imm);
        instr_valid  = 1'b1;
        instr_op     = op;
        instr_rd     = rd;
        instr_rs1    = rs1;
        instr_rs2    = rs2;
        instr_imm_en = ie;
        instr_imm    = imm;
        tick();
    endtask

    task automatic idle();
        instr_valid = 1'b0;
        instr_op    = 8'h00;
        tick();
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_op = 8'h00; instr_rd = 3'd0; instr_rs1 = 3'd0;
        instr_rs2 = 3'd0; instr_imm_en = 1'b0; instr_imm = 16'd0; resume = 1'b0;
        tick();
        resume = 1'b1; instr_valid = 1'b1;
        tick();
        resume = 1'b0; instr_valid = 1'b0;
        check("rst_ready_low", instr_ready, 1'b0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_rd", wb_rd, 3'd0);
        check("rst_wb_data", wb_data, 16'd0);
        check("rst_flags", flags_q, 4'h0);
        check("rst_err", err, 1'b0);
        check("rst_opcode", alu_opcode, 8'h00);
        check("rst_alu_a", alu_a, 16'd0);
        check("rst_alu_b", alu_b, 16'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", instr_ready, 1'b1);

        // ADD r1 = r0 + 5
        issue(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005);
        check("add5_ex_opcode", alu_opcode, 8'h01);
        check("add5_ex_b", alu_b, 16'h0005);
        check("add5_no_wb_yet", wb_valid, 1'b0);
        idle();
        check("add5_wb_valid", wb_valid, 1'b1);
        check("add5_wb_rd", wb_rd, 3'd1);
        check("add5_wb_data", wb_data, 16'h0005);
        check("add5_flags", flags_q, 4'h0);
        check("add5_ex_empty", alu_opcode, 8'h00);
        check("add5_ex_b_hold", alu_b, 16'h0005);
        idle();
        check("add5_wb_one_cycle", wb_valid, 1'b0);

        // Back-to-back forwarding with signed overflow
        issue(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF);
        issue(8'h01, 3'd2, 3'd1, 3'd1, 1'b0, 16'h0000);
        check("fwd_alu_a", alu_a, 16'h7FFF);
        check("fwd_alu_b", alu_b, 16'h7FFF);
        check("fwd_first_wb", wb_data, 16'h7FFF);
        idle();
        check("fwd_wb_rd", wb_rd, 3'd2);
        check("fwd_wb_data", wb_data, 16'hFFFE);
        check("fwd_flags", flags_q, 4'hA);

        // SUB borrow, then AND updates only zero/overflow
        issue(8'h02, 3'd3, 3'd0, 3'd0, 1'b1, 16'h0001);
        issue(8'h03, 3'd4, 3'd3, 3'd0, 1'b0, 16'h0000);
        check("sub_wb_data", wb_data, 16'hFFFF);
        check("sub_flags", flags_q, 4'h3);
        check("and_fwd_a", alu_a, 16'hFFFF);
        idle();
        check("and_wb_data", wb_data, 16'h0000);
        check("and_flags", flags_q, 4'h7);

        // Writes to r0 are discarded but still notified
        issue(8'h01, 3'd0, 3'd0, 3'd0, 1'b1, 16'h0009);
        issue(8'h01, 3'd5, 3'd0, 3'd0, 1'b1, 16'h0000);
        check("r0_no_fwd", alu_a, 16'h0000);
        check("r0_wb_valid", wb_valid, 1'b1);
        check("r0_wb_rd", wb_rd, 3'd0);
        check("r0_wb_data", wb_data, 16'h0009);
        idle();
        check("r5_wb_rd", wb_rd, 3'd5);
        check("r5_wb_data", wb_data, 16'h0000);
        check("r5_flags", flags_q, 4'h4);

        // HALT behind an ADD, resume, illegal opcode
        issue(8'h01, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0007);
        issue(8'hFF, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0000);
        check("halt_add_commits", wb_valid, 1'b1);
        check("halt_add_data", wb_data, 16'h0007);
        check("halt_ready_low", instr_ready, 1'b0);
        check("halt_ex_empty", alu_opcode, 8'h00);
        issue(8'h01, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0055);
        check("halt_no_wb", wb_valid, 1'b0);
        check("halt_not_accepted", alu_opcode, 8'h00);
        tick();
        check("halt_still_low", instr_ready, 1'b0);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("resume_ready", instr_ready, 1'b1);
        check("resume_nothing_taken", alu_opcode, 8'h00);
        tick();
        check("post_resume_op", alu_opcode, 8'h01);
        check("post_resume_b", alu_b, 16'h0055);
        resume = 1'b1;
        idle();
        resume = 1'b0;
        check("post_resume_wb", wb_data, 16'h0055);
        check("post_resume_rd", wb_rd, 3'd2);
        check("resume_in_run_ignored", instr_ready, 1'b1);
        issue(8'h20, 3'd6, 3'd0, 3'd0, 1'b1, 16'h1234);
        check("illegal_err_before", err, 1'b0);
        idle();
        check("illegal_err", err, 1'b1);
        check("illegal_no_wb", wb_valid, 1'b0);
        check("illegal_flags", flags_q, 4'h0);
        idle();
        check("err_sticky", err, 1'b1);

        // Reset while an ADD sits in EX
        issue(8'h01, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0003);
        check("pre_rst_ex", alu_opcode, 8'h01);
        rst = 1'b1; instr_valid = 1'b0;
        tick();
        check("mid_rst_wb_valid", wb_valid, 1'b0);
        check("mid_rst_ready", instr_ready, 1'b0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_opcode", alu_opcode, 8'h00);
        check("mid_rst_alu_b", alu_b, 16'h0000);
        check("mid_rst_wb_data", wb_data, 16'h0000);
        check("mid_rst_flags", flags_q, 4'h0);
        rst = 1'b0;
        issue(8'h01, 3'd7, 3'd6, 3'd0, 1'b1, 16'h0000);
        check("r6_read_zero", alu_a, 16'h0000);
        idle();
        check("r7_wb_rd", wb_rd, 3'd7);
        check("r7_wb_data", wb_data, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter DATA_W, default 16, datapath width.
REQ-002 Parameter NREGS, default 8, register-file depth; index width 3.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 instr_valid  in  1  instruction offered.
REQ-006 instr_ready  out  1  dispatch accepts; transfer on edge where valid&ready.
REQ-007 instr_op  in  8  ALU opcode; 0x00 NOP, 0x01-0x11 ALU ops, 0xFF HALT.
REQ-008 instr_rd, instr_rs1, instr_rs2  in  3 each  destination and source register indices.
REQ-009 instr_imm_en  in  1  select instr_imm instead of rs2 for operand B.
REQ-010 instr_imm  in  16  immediate operand.
REQ-011 resume  in  1  leaves HALT.
REQ-012 alu_opcode  out  8; alu_a, alu_b  out  16 signed  registered EX-stage operands to ALU.
REQ-013 alu_result  in  16 signed; alu_flags  in  16  combinational ALU return.
REQ-014 wb_valid  out  1; wb_rd  out  3; wb_data  out  16  registered writeback notification.
REQ-015 flags_q  out  4  {overflow, zero, negative, carry} architectural flags, bit0 = carry.
REQ-016 err  out  1  sticky illegal-opcode indicator.

Function
REQ-017 Two stages: acceptance edge N loads EX registers; edge N+1 commits result; wb_valid high for the cycle following edge N+1 only.
REQ-018 States RUN and HALT; instr_ready = (state==RUN) and not rst; no backpressure in RUN, one instruction per cycle.
REQ-019 Operand A = R[rs1]; operand B = instr_imm if imm_en else R[rs2]; R0 always reads 0.
REQ-020 Forwarding: if EX holds a writing instruction with ex_rd==rs (rs!=0), source takes alu_result instead of register file.
REQ-021 Opcodes 0x01-0x11 write alu_result[15:0] to R[rd] at commit; rd==0 write discarded, wb_valid still pulses with wb_rd=0.
REQ-022 NOP (0x00): occupies EX, no register write, no flag update, no wb_valid.
REQ-023 flags_q: zero (alu_flags[2]) and overflow (alu_flags[3]) update on every committed 0x01-0x11 op; carry (alu_flags[0]) and negative (alu_flags[1]) update only for 0x01/0x02, otherwise hold.
REQ-024 HALT (0xFF): accepted, state -> HALT from next cycle, no write, no flag change; instruction already in EX still commits.
REQ-025 In HALT, resume=1 at an edge -> RUN at that edge; resume in RUN ignored.
REQ-026 Opcodes 0x12-0xFE: treated as NOP and err set to 1 at commit; err cleared only by rst.
REQ-027 alu_opcode driven 0x00 when EX empty; alu_a/alu_b hold last values.

Reset
REQ-028 rst dominates all inputs including resume and instr_valid.
REQ-029 On rst edge: all registers R0-R7 = 0, EX empty, state=RUN, flags_q=0, err=0, wb_valid=0, wb_rd=0, wb_data=0, alu_opcode=0, alu_a=alu_b=0.
REQ-030 rst mid-operation discards the EX instruction without register write or flag update; instr_ready low while rst high.

Structure
REQ-031 Shared package alu_pkg holds opcode constants (OP_NOP, OP_ADD, OP_SUB ... OP_NEG1, OP_HALT), flag bit indices and DATA_W.
REQ-032 Register file is one sub-module, regfile (2 combinational read ports, 1 synchronous write port, R0 hardwired zero); ALU stays external.

Verification
REQ-033 Post-reset, ADD r1=r0+imm 5 accepted at edge N -> wb_valid, wb_rd=1, wb_data=0x0005 after edge N+1; zero=0.
REQ-034 ADD r1=r0+imm 0x7FFF then back-to-back ADD r2=r1+r1 -> forwarded, wb_data=0xFFFE, flags_q overflow=1, negative=1.
REQ-035 SUB r3=r0-imm 1 -> wb_data=0xFFFF, negative=1; following AND r4=r3&r0 -> zero=1, carry/negative unchanged.
REQ-036 ADD r0=r0+imm 9, then ADD r5=r0+imm 0 -> second wb_data=0x0000; r0 never nonzero.
REQ-037 HALT after ADD -> ADD still commits, instr_ready low until resume pulse, high the cycle after; opcode 0x20 -> err=1, no write.
REQ-038 rst asserted one cycle after accepting ADD r6=imm 3 -> no wb_valid, r6 reads 0, all outputs at REQ-029 values.
